efpga_cfg_bridge: RTL and testbench
===================================

// Module: efpga_cfg_bridge
// PURPOSE
//  CPU-side configuration bridge directly upstream of the eFPGA CPU configuration port.
//  - Takes 32-bit bitstream words written by the RISC-V over a simple register bus.
//  - Buffers them in a FIFO.
//  - Replays each word to the fabric as a WriteData word with a one-cycle WriteStrobe.
//  - Enforces a programmable idle gap between strobes.
//  - Yields to the UART configuration path while ComActive is high.
// PARAMETERS
//  FIFO_DEPTH   8   FIFO entries; power of 2, >=2
//  STROBE_GAP   2   idle cycles forced after each strobe (0 = back-to-back strobes allowed)
// PORTS
//  CLK          in   1   system clock, shared with the eFPGA CLK
//  resetn       in   1   asynchronous active-low reset
//  bus_sel      in   1   access request; held high until bus_ready
//  bus_we       in   1   1=write, 0=read; sampled with bus_sel
//  bus_addr     in   4   byte address (0x0,0x4,0x8,0xC); bits[1:0] ignored
//  bus_wdata    in   32  write data
//  bus_rdata    out  32  read data, valid while bus_ready=1
//  bus_ready    out  1   one-cycle completion pulse
//  uart_active  in   1   eFPGA ComActive; high = UART owns config port
//  WriteStrobe  out  1   config write strobe to eFPGA
//  WriteData    out  32  config data to eFPGA
//  cfg_busy     out  1   FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0; FIFO empty; FSM=IDLE; all registers 0.
//  Bus protocol:
//   - Access accepted when bus_sel=1 && bus_ready=0.
//   - bus_ready is a registered pulse in the following cycle, so latency = 1 cycle.
//   - bus_rdata=0 when bus_ready=0.
//  Register map:
//   0x0 DATA   W: push bus_wdata into FIFO. R: 0.
//   0x4 CTRL   RW bit0 EN. W bit1 FLUSH (self-clearing; reads 0). W bit2 CLR_OVF (self-clearing).
//   0x8 STATUS R: [7:0] FIFO level, [8] full, [9] empty, [10] OVF (sticky), [11] cfg_busy.
//   0xC COUNT  R: [15:0] words strobed since reset; wraps 0xFFFF->0. W: clears to 0.
//  FIFO:
//   - Push to DATA when level==FIFO_DEPTH and no pop in the same cycle: word dropped, OVF set.
//   - Push and pop in the same cycle when full: both succeed; level is unchanged.
//   - FLUSH empties the FIFO in 1 cycle. It does not abort a strobe already in STROBE or GAP.
//   - FLUSH wins over a simultaneous push.
//  FSM (IDLE, STROBE, GAP):
//   IDLE->STROBE:
//    - Taken when EN=1, FIFO non-empty and uart_active=0.
//    - On that edge, pop the FIFO head into WriteData.
//   STROBE:
//    - WriteStrobe=1 for exactly 1 cycle; COUNT increments.
//    - Exit to GAP if STROBE_GAP>0, else to IDLE.
//   GAP:
//    - WriteStrobe=0; gap counter runs STROBE_GAP cycles, then IDLE.
//   - WriteData holds its last value outside STROBE.
//   - First strobe is 2 cycles after the DATA write accept edge.
//   - Throughput: 1 word per (1+STROBE_GAP+1) cycles, or 1/cycle-pair when STROBE_GAP=0.
//  Boundary rules:
//   - uart_active rising during STROBE/GAP: the current strobe completes. No new pop until uart_active=0.
//   - EN cleared mid-sequence: the current STROBE/GAP completes, then IDLE. FIFO contents are retained.
//   - resetn asserted mid-strobe: WriteStrobe drops immediately (async). Buffered words are lost.
// TESTING
//  1 Reset: resetn=0 with FIFO holding 3 words -> WriteStrobe=0, STATUS=0x200 after release, COUNT=0.
//  2 EN=1, write DATA 0xDEADBEEF, 0x12345678 (STROBE_GAP=2):
//    -> WriteStrobe pulses with WriteData=0xDEADBEEF, then 0x12345678, 4 cycles apart; COUNT=2.
//  3 EN=0, write 9 words (FIFO_DEPTH=8) -> STATUS level=8, full=1, OVF=1; 9th word never strobed.
//    CLR_OVF -> OVF=0.
//  4 uart_active=1, EN=1, 2 words queued -> no WriteStrobe.
//    uart_active=0 -> both words strobed in order.
//  5 FLUSH issued during GAP after the 1st of 4 words:
//    -> exactly 1 strobe total, level=0, cfg_busy=0 after the gap ends.
//  6 Preload COUNT path: 65536 strobes (or force) -> COUNT wraps to 0x0000; write COUNT -> 0.

Source files
------------

// File: rtl/efpga_cfg_bridge.sv
// CPU-side configuration bridge: buffers bitstream words written over a simple
// register bus and replays them to the eFPGA config port as gapped write strobes.
module efpga_cfg_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int STROBE_GAP = 2
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        uart_active,
  output logic        WriteStrobe,
  output logic [31:0] WriteData,
  output logic        cfg_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((STROBE_GAP > 0) ? STROBE_GAP - 1 : 0);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     count_q, count_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            bus_ready_q, bus_ready_d;
  logic [31:0]     bus_rdata_q, bus_rdata_d;

  logic            accept;
  logic [1:0]      reg_sel;
  logic            wr_data, wr_ctrl, wr_count;
  logic            flush;
  logic            fifo_full, fifo_empty;
  logic            pop, push_ok, overflow;
  logic [31:0]     status_word;
  logic [31:0]     read_mux;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];

  assign accept   = bus_sel && !bus_ready_q;
  assign reg_sel  = bus_addr[3:2];
  assign wr_data  = accept && bus_we && (reg_sel == REG_DATA);
  assign wr_ctrl  = accept && bus_we && (reg_sel == REG_CTRL);
  assign wr_count = accept && bus_we && (reg_sel == REG_COUNT);
  assign flush    = wr_ctrl && bus_wdata[1];

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // A flush in the same cycle also holds off launching a new strobe so the
  // FIFO really ends up empty.
  assign pop      = (state_q == ST_IDLE) && en_q && !fifo_empty && !uart_active && !flush;
  assign push_ok  = wr_data && !flush && (!fifo_full || pop);
  assign overflow = wr_data && !flush && fifo_full && !pop;

  assign cfg_busy    = !fifo_empty || (state_q != ST_IDLE);
  assign status_word = {20'd0, cfg_busy, ovf_q, fifo_empty, fifo_full, 8'(level_q)};

  always_comb begin
    read_mux = 32'd0;
    case (reg_sel)
      REG_DATA:   read_mux = 32'd0;
      REG_CTRL:   read_mux = {31'd0, en_q};
      REG_STATUS: read_mux = status_word;
      REG_COUNT:  read_mux = {16'd0, count_q};
      default:    read_mux = 32'd0;
    endcase
  end

  always_comb begin
    bus_ready_d = accept;
    bus_rdata_d = (accept && !bus_we) ? read_mux : 32'd0;

    en_d  = wr_ctrl ? bus_wdata[0] : en_q;
    ovf_d = ovf_q;
    if (overflow) begin
      ovf_d = 1'b1;
    end else if (wr_ctrl && bus_wdata[2]) begin
      ovf_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push_ok) - LW'(pop);
    end

    wdata_d = pop ? mem_q[rd_ptr_q] : wdata_q;

    count_d = count_q;
    if (wr_count) begin
      count_d = 16'd0;
    end else if (state_q == ST_STROBE) begin
      count_d = count_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (STROBE_GAP > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      en_q        <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= 16'd0;
      wdata_q     <= 32'd0;
      bus_ready_q <= 1'b0;
      bus_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      en_q        <= en_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      bus_ready_q <= bus_ready_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus_wdata;
    end
  end

  assign WriteStrobe = (state_q == ST_STROBE);
  assign WriteData   = wdata_q;
  assign bus_ready   = bus_ready_q;
  assign bus_rdata   = bus_rdata_q;

endmodule

// File: tb/tb_efpga_cfg_bridge.sv
// Self-checking bench for efpga_cfg_bridge: random bitstream words are checked
// against a queue-based model of the words the fabric should receive, in order.
module tb_efpga_cfg_bridge;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;

  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_CTRL   = 4'h4;
  localparam logic [3:0] A_STATUS = 4'h8;
  localparam logic [3:0] A_COUNT  = 4'hC;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        uart_active = 1'b0;
  logic        WriteStrobe;
  logic [31:0] WriteData;
  logic        cfg_busy;

  efpga_cfg_bridge #(.FIFO_DEPTH(DEPTH), .STROBE_GAP(GAP)) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .bus_sel    (bus_sel),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .uart_active(uart_active),
    .WriteStrobe(WriteStrobe),
    .WriteData  (WriteData),
    .cfg_busy   (cfg_busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Everything the fabric would latch, with the cycle it was seen in.
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  always @(negedge CLK) begin
    if (WriteStrobe === 1'b1) begin
      obs_data.push_back(WriteData);
      obs_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;

  function automatic logic [31:0] status_exp(input int level, input logic ovf, input logic busy);
    logic [7:0] lv;
    lv = 8'(level);
    return {20'd0, busy, ovf, (level == 0), (level == DEPTH), lv};
  endfunction

  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int acc_cyc);
    int n;
    @(negedge CLK);
    bus_sel = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus_ready !== 1'b1 && n < 10);
    checks++;
    if (bus_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_ready_timeout addr=%h got=%b exp=1", addr, bus_ready);
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL bus_latency addr=%h got=%0d exp=1", addr, n);
    end
    rd = bus_rdata;
    acc_cyc = cyc;
    bus_sel = 1'b0; bus_we = 1'b0;
    $display("bus %s addr=%h wdata=%h rdata=%h", we ? "WR" : "RD", addr, wd, rd);
    @(negedge CLK);
    checks++;
    if (bus_ready !== 1'b0 || bus_rdata !== 32'd0) begin
      errors++;
      $display("FAIL bus_ready_pulse got ready=%b rdata=%h exp ready=0 rdata=0", bus_ready, bus_rdata);
    end
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    int ac;
    bus_xfer(1'b1, addr, wd, rd, ac);
  endtask

  task automatic reg_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int ac;
    bus_xfer(1'b0, addr, 32'd0, rd, ac);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, rd, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    reg_write(A_DATA, w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cfg_busy !== 1'b0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout got cfg_busy=%b exp=0", name, cfg_busy);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_strobes(input string name);
    checks++;
    if (obs_data.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s strobe_count got=%0d exp=%0d", name, obs_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_data[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s word%0d got=%h exp=%h", name, i, obs_data[i], exp_q[i]);
        end
        if (i > 0) begin
          checks++;
          if (obs_cyc[i] - obs_cyc[i-1] < GAP + 2) begin
            errors++;
            $display("FAIL %s spacing%0d got=%0d exp>=%0d", name, i, obs_cyc[i] - obs_cyc[i-1], GAP + 2);
          end
        end
      end
    end
    exp_count = exp_count + 16'(exp_q.size());
    obs_data.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    resetn = 1'b0;
    #1;
    checks++;
    if (WriteStrobe !== 1'b0 || cfg_busy !== 1'b0 || bus_ready !== 1'b0 || bus_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got strobe=%b busy=%b ready=%b rdata=%h exp all 0",
               WriteStrobe, cfg_busy, bus_ready, bus_rdata);
    end
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    obs_data.delete(); obs_cyc.delete(); exp_q.delete();
    exp_count = 16'd0;
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    checks++;
    if (WriteData !== 32'd0) begin
      errors++;
      $display("FAIL reset_wdata got=%h exp=0", WriteData);
    end
    reg_check("reset_status", A_STATUS, status_exp(0, 1'b0, 1'b0));
    reg_check("reset_count", A_COUNT, 32'd0);
    reg_check("reset_ctrl", A_CTRL, 32'd0);
    for (int i = 0; i < 3; i++) reg_write(A_DATA, $urandom);
    reg_check("preload_status", A_STATUS, status_exp(3, 1'b0, 1'b1));
    apply_reset();
    reg_check("reset3_status", A_STATUS, status_exp(0, 1'b0, 1'b0));
    reg_check("reset3_count", A_COUNT, 32'd0);
    // Reset asserted while a strobe is on the wire must kill it at once.
    for (int i = 0; i < 3; i++) reg_write(A_DATA, $urandom);
    reg_write(A_CTRL, 32'd1);
    n = 0;
    while (WriteStrobe !== 1'b1 && n < 10) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (WriteStrobe !== 1'b1) begin
      errors++;
      $display("FAIL midstrobe_wait got=%b exp=1", WriteStrobe);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (WriteStrobe !== 1'b0) begin
      errors++;
      $display("FAIL async_strobe_drop got=%b exp=0", WriteStrobe);
    end
    @(negedge CLK);
    @(negedge CLK);
    resetn = 1'b1;
    obs_data.delete(); obs_cyc.delete(); exp_q.delete();
    exp_count = 16'd0;
    reg_check("midstrobe_status", A_STATUS, status_exp(0, 1'b0, 1'b0));
    reg_check("midstrobe_count", A_COUNT, 32'd0);
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    int a1, a2;
    reg_write(A_CTRL, 32'd1);
    bus_xfer(1'b1, A_DATA, 32'hDEADBEEF, rd, a1);
    exp_q.push_back(32'hDEADBEEF);
    bus_xfer(1'b1, A_DATA, 32'h12345678, rd, a2);
    exp_q.push_back(32'h12345678);
    wait_idle("basic");
    checks++;
    if (obs_cyc.size() !== 2) begin
      errors++;
      $display("FAIL basic_timing_count got=%0d exp=2", obs_cyc.size());
    end else begin
      // The fabric samples the strobe on the second edge after the write is accepted.
      checks++;
      if (obs_cyc[0] !== a1 + 1) begin
        errors++;
        $display("FAIL first_strobe_latency got=%0d exp=%0d", obs_cyc[0] - a1, 1);
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] !== GAP + 2) begin
        errors++;
        $display("FAIL strobe_period got=%0d exp=%0d", obs_cyc[1] - obs_cyc[0], GAP + 2);
      end
    end
    check_strobes("basic");
    reg_check("basic_count", A_COUNT, {16'd0, exp_count});
    for (int i = 0; i < 6; i++) push_word($urandom);
    wait_idle("random_burst");
    check_strobes("random_burst");
    reg_check("burst_count", A_COUNT, {16'd0, exp_count});
  endtask

  task automatic test_overflow();
    int level;
    logic ovf;
    reg_write(A_CTRL, 32'd0);
    level = 0;
    ovf = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [31:0] w;
      w = $urandom;
      reg_write(A_DATA, w);
      if (level < DEPTH) begin
        level++;
        exp_q.push_back(w);
      end else begin
        ovf = 1'b1;
      end
    end
    reg_check("ovf_status", A_STATUS, status_exp(level, ovf, 1'b1));
    reg_write(A_CTRL, 32'd4);
    reg_check("clr_ovf_status", A_STATUS, status_exp(level, 1'b0, 1'b1));
    reg_write(A_CTRL, 32'd1);
    wait_idle("overflow_drain");
    check_strobes("overflow_drain");
    reg_check("ovf_drained_status", A_STATUS, status_exp(0, 1'b0, 1'b0));
    reg_check("ovf_count", A_COUNT, {16'd0, exp_count});
  endtask

  task automatic test_uart();
    uart_active = 1'b1;
    reg_write(A_CTRL, 32'd1);
    push_word($urandom);
    push_word($urandom);
    repeat (20) @(negedge CLK);
    checks++;
    if (obs_data.size() !== 0) begin
      errors++;
      $display("FAIL uart_hold got=%0d strobes exp=0", obs_data.size());
    end
    reg_check("uart_hold_status", A_STATUS, status_exp(2, 1'b0, 1'b1));
    uart_active = 1'b0;
    wait_idle("uart_release");
    check_strobes("uart_release");
    // UART grabbing the port mid-strobe lets that strobe finish but blocks the next.
    reg_write(A_CTRL, 32'd0);
    for (int i = 0; i < 3; i++) push_word($urandom);
    reg_write(A_CTRL, 32'd1);
    uart_active = 1'b1;
    repeat (20) @(negedge CLK);
    checks++;
    if (obs_data.size() !== 1) begin
      errors++;
      $display("FAIL uart_midstrobe got=%0d strobes exp=1", obs_data.size());
    end
    uart_active = 1'b0;
    wait_idle("uart_midstrobe");
    check_strobes("uart_midstrobe");
  endtask

  task automatic test_en_clear();
    reg_write(A_CTRL, 32'd0);
    for (int i = 0; i < 3; i++) push_word($urandom);
    reg_write(A_CTRL, 32'd1);
    reg_write(A_CTRL, 32'd0);
    repeat (20) @(negedge CLK);
    checks++;
    if (obs_data.size() !== 1) begin
      errors++;
      $display("FAIL en_clear got=%0d strobes exp=1", obs_data.size());
    end
    reg_check("en_clear_status", A_STATUS, status_exp(2, 1'b0, 1'b1));
    reg_write(A_CTRL, 32'd1);
    wait_idle("en_resume");
    check_strobes("en_resume");
  endtask

  task automatic test_flush();
    logic [31:0] first;
    reg_write(A_CTRL, 32'd0);
    first = $urandom;
    reg_write(A_DATA, first);
    for (int i = 0; i < 3; i++) reg_write(A_DATA, $urandom);
    exp_q.push_back(first);
    reg_write(A_CTRL, 32'd1);
    reg_write(A_CTRL, 32'd3);
    wait_idle("flush");
    checks++;
    if (cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got=%b exp=0", cfg_busy);
    end
    check_strobes("flush");
    reg_check("flush_status", A_STATUS, status_exp(0, 1'b0, 1'b0));
    reg_check("flush_ctrl_readback", A_CTRL, 32'd1);
    reg_check("flush_count", A_COUNT, {16'd0, exp_count});
  endtask

  task automatic test_count_wrap();
    @(negedge CLK);
    force dut.count_q = 16'hFFFE;
    @(negedge CLK);
    release dut.count_q;
    exp_count = 16'hFFFE;
    reg_check("count_preload", A_COUNT, 32'h0000FFFE);
    push_word($urandom);
    push_word($urandom);
    wait_idle("wrap");
    check_strobes("wrap");
    reg_check("count_wrap", A_COUNT, {16'd0, exp_count});
    push_word($urandom);
    wait_idle("post_wrap");
    check_strobes("post_wrap");
    reg_check("count_post_wrap", A_COUNT, {16'd0, exp_count});
    reg_write(A_COUNT, $urandom);
    exp_count = 16'd0;
    reg_check("count_clear", A_COUNT, 32'd0);
  endtask

  initial begin
    fork
      begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_basic();
    test_overflow();
    test_uart();
    test_en_clear();
    test_flush();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
